rr_dec_arbiter: RTL and testbench

RR_DEC_ARBITER -- requirements
Module: rr_dec_arbiter

---
 rtl/rr_dec_arbiter.sv | 107 ++++++++++
 tb/tb_rr_dec_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter over 8 requesters driving a shared 3-to-8 decoder.
// One idle gap cycle between grants gives break-before-make on the decoder.
module rr_dec_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] gnt_idx,
   output logic       En,
   output logic [7:0] grant,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   logic [2:0] ptr, ptr_nx;
   logic [7:0] hold, hold_nx;
   logic [2:0] idx_nx;
   logic       en_nx;
   logic       terr_nx;
   logic [7:0] grant_nx;
   logic [2:0] pick;
   logic [2:0] cand;
   logic       armed;

   // Scan downward so the nearest set bit after ptr is the last one written.
   always_comb begin
      pick = ptr;
      cand = '0;
      for (int i = 8; i >= 1; i--) begin
         cand = ptr + 3'(i);
         if (req[cand]) pick = cand;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      hold_nx  = hold;
      idx_nx   = gnt_idx;
      en_nx    = 1'b0;
      terr_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            // armed holds off the first grant until the second edge after reset
            if (armed && (req != 8'h00)) begin
               state_nx = GRANT;
               en_nx    = 1'b1;
               idx_nx   = pick;
               ptr_nx   = pick;
               hold_nx  = 8'h00;
            end
         end
         GRANT: begin
            en_nx   = 1'b1;
            hold_nx = hold + 8'h01;
            if (done || !req[gnt_idx]) begin
               state_nx = GAP;
               en_nx    = 1'b0;
            end else if (hold == HOLD_MAX) begin
               state_nx = GAP;
               en_nx    = 1'b0;
               terr_nx  = 1'b1;
            end
         end
         GAP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      grant_nx = en_nx ? (8'h01 << idx_nx) : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd7;
         hold        <= 8'h00;
         gnt_idx     <= 3'd0;
         En          <= 1'b0;
         grant       <= 8'h00;
         timeout_err <= 1'b0;
         armed       <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         hold        <= hold_nx;
         gnt_idx     <= idx_nx;
         En          <= en_nx;
         grant       <= grant_nx;
         timeout_err <= terr_nx;
         armed       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed bench for rr_dec_arbiter.
// Expected outputs are queued per cycle and checked after each edge.
module tb_rr_dec_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] gnt_idx;
   logic       En;
   logic [7:0] grant;
   logic       timeout_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       en;
      logic [2:0] idx;
      logic       terr;
      string      tag;
   } exp_t;

   exp_t q[$];

   rr_dec_arbiter #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .gnt_idx    (gnt_idx),
      .En         (En),
      .grant      (grant),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_zero(input string tag);
      checks++;
      assert (En === 1'b0) else begin
         errors++;
         $error("FAIL %s En got %0b exp 0", tag, En);
      end
      checks++;
      assert (grant === 8'h00) else begin
         errors++;
         $error("FAIL %s grant got %h exp 00", tag, grant);
      end
      checks++;
      assert (gnt_idx === 3'd0) else begin
         errors++;
         $error("FAIL %s gnt_idx got %0d exp 0", tag, gnt_idx);
      end
      checks++;
      assert (timeout_err === 1'b0) else begin
         errors++;
         $error("FAIL %s timeout_err got %0b exp 0", tag, timeout_err);
      end
   endtask

   // Drive one cycle of stimulus, queue what must appear after the edge.
   task automatic cyc(input logic [7:0] r, input logic d,
                      input logic e_en, input logic [2:0] e_idx,
                      input logic e_terr, input string tag);
      exp_t       e;
      logic [7:0] g;
      req  = r;
      done = d;
      q.push_back('{en: e_en, idx: e_idx, terr: e_terr, tag: tag});
      @(posedge clk);
      #1;
      e = q.pop_front();
      g = e.en ? (8'h01 << e.idx) : 8'h00;
      checks++;
      assert (En === e.en) else begin
         errors++;
         $error("FAIL %s En got %0b exp %0b", e.tag, En, e.en);
      end
      checks++;
      assert (grant === g) else begin
         errors++;
         $error("FAIL %s grant got %h exp %h", e.tag, grant, g);
      end
      checks++;
      assert (timeout_err === e.terr) else begin
         errors++;
         $error("FAIL %s timeout_err got %0b exp %0b",
                e.tag, timeout_err, e.terr);
      end
      if (e.en) begin
         checks++;
         assert (gnt_idx === e.idx) else begin
            errors++;
            $error("FAIL %s gnt_idx got %0d exp %0d",
                   e.tag, gnt_idx, e.idx);
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // single request, first grant on second edge after reset
      cyc(8'h01, 1'b0, 1'b0, 3'd0, 1'b0, "arm");
      cyc(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "single_g0");
      cyc(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "single_hold");
      cyc(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, "single_done");
      cyc(8'h01, 1'b0, 1'b0, 3'd0, 1'b0, "single_idle");
      cyc(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "single_regrant");

      // asynchronous reset mid-grant
      req = 8'h81;
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(8'h81, 1'b0, 1'b0, 3'd0, 1'b0, "rst_arm");
      cyc(8'h81, 1'b0, 1'b1, 3'd0, 1'b0, "rst_g0");
      cyc(8'h81, 1'b1, 1'b0, 3'd0, 1'b0, "rst_done");
      cyc(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "rst_idle");

      // full rotation from a fresh pointer
      do_reset();
      cyc(8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, "rot_arm");
      for (int k = 0; k < 9; k++) begin
         cyc(8'hFF, 1'b0, 1'b1, 3'(k), 1'b0, "rot_grant");
         cyc(8'hFF, 1'b0, 1'b1, 3'(k), 1'b0, "rot_hold1");
         cyc(8'hFF, 1'b0, 1'b1, 3'(k), 1'b0, "rot_hold2");
         cyc(8'hFF, 1'b1, 1'b0, 3'(k), 1'b0, "rot_gap");
         cyc(8'hFF, 1'b0, 1'b0, 3'(k), 1'b0, "rot_idle");
      end

      // timeout: 16 cycles of grant, then error pulse in the gap
      cyc(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to_grant");
      for (int k = 0; k < 15; k++)
         cyc(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to_hold");
      cyc(8'h20, 1'b0, 1'b0, 3'd5, 1'b1, "to_err");
      cyc(8'h20, 1'b0, 1'b0, 3'd5, 1'b0, "to_idle");
      cyc(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to_regrant");

      // done on the timeout cycle suppresses the error
      for (int k = 0; k < 15; k++)
         cyc(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "co_hold");
      cyc(8'h20, 1'b1, 1'b0, 3'd5, 1'b0, "co_release");

      // withdrawal and wrap-around from ptr 6
      cyc(8'h40, 1'b0, 1'b0, 3'd0, 1'b0, "wd_idle0");
      cyc(8'h40, 1'b0, 1'b1, 3'd6, 1'b0, "wd_g6");
      cyc(8'h40, 1'b1, 1'b0, 3'd6, 1'b0, "wd_gap0");
      cyc(8'h41, 1'b0, 1'b0, 3'd6, 1'b0, "wd_idle1");
      cyc(8'h41, 1'b0, 1'b1, 3'd0, 1'b0, "wd_wrap_g0");
      cyc(8'hC3, 1'b0, 1'b1, 3'd0, 1'b0, "wd_ignore_others");
      cyc(8'h40, 1'b0, 1'b0, 3'd0, 1'b0, "wd_withdraw");
      cyc(8'h40, 1'b0, 1'b0, 3'd0, 1'b0, "wd_idle2");
      cyc(8'h40, 1'b0, 1'b1, 3'd6, 1'b0, "wd_g6_again");

      // done outside GRANT has no effect
      cyc(8'h00, 1'b0, 1'b0, 3'd6, 1'b0, "od_withdraw");
      cyc(8'h00, 1'b1, 1'b0, 3'd6, 1'b0, "od_gap_done");
      cyc(8'h00, 1'b1, 1'b0, 3'd6, 1'b0, "od_idle_done");
      cyc(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "od_g3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
